// File: rtl/shift_pkg.sv
// Shared types for the shift arbiter: shift modes, FSM states, widths.
// No ports; imported by shifter_32bit and shift_arbiter.
package shift_pkg;

    typedef enum logic [1:0] {
        SRL = 2'b00,
        SLL = 2'b01,
        SRA = 2'b10,
        RSV = 2'b11
    } shift_mode_e;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } arb_state_e;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/shifter_32bit.sv
// Combinational 32-bit shifter (SRL/SLL/SRA, RSV passes data through).
// Ports: data, shamt (full 32-bit amount), mode in; result out.
module shifter_32bit
    import shift_pkg::*;
(
    input  logic [31:0] data,
    input  logic [31:0] shamt,
    input  shift_mode_e mode,
    output logic [31:0] result
);

    logic       big;
    logic [4:0] sh;

    assign big = |shamt[31:5];
    assign sh  = shamt[4:0];

    // Any amount of 32 or more clears the result, for every mode.
    always_comb begin
        result = '0;
        unique case (mode)
            SRL: result = data >> sh;
            SLL: result = data << sh;
            SRA: result = $signed(data) >>> sh;
            RSV: result = data;
            default: result = '0;
        endcase
        if (big) result = '0;
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter (ALU, LSU) in front of one shared shifter.
// Ports: clk, rst_n, flush, req_valid/ready[1:0], req{0,1}_{data,shamt,mode},
//        rsp_valid/ready, rsp_id, rsp_data, stall_cnt.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [31:0]            req0_data,
    input  logic [31:0]            req1_data,
    input  logic [31:0]            req0_shamt,
    input  logic [31:0]            req1_shamt,
    input  logic [1:0]             req0_mode,
    input  logic [1:0]             req1_mode,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [31:0]            rsp_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    arb_state_e state_q, state_d;
    logic       last_grant;
    logic [1:0] grant;
    logic       out_free;
    logic       accept;
    logic       sel;
    logic [31:0] sh_data;
    logic [31:0] sh_amt;
    logic [1:0]  sh_mode;
    logic [31:0] sh_res;

    assign rsp_valid = (state_q == HOLD);
    assign out_free  = ~rsp_valid | rsp_ready;

    // With both requesting, round-robin favours whoever did not win last.
    always_comb begin
        grant = 2'b00;
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (RR_EN && !last_grant) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // rst_n gates ready so nothing is offered while reset is held.
    assign req_ready = {2{out_free & ~flush & rst_n}} & grant;
    assign accept    = |req_ready;
    assign sel       = grant[1];

    assign sh_data = sel ? req1_data  : req0_data;
    assign sh_amt  = sel ? req1_shamt : req0_shamt;
    assign sh_mode = sel ? req1_mode  : req0_mode;

    shifter_32bit u_shifter (
        .data   (sh_data),
        .shamt  (sh_amt),
        .mode   (shift_mode_e'(sh_mode)),
        .result (sh_res)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = HOLD;
            HOLD: begin
                if (flush)          state_d = EMPTY;
                else if (accept)    state_d = HOLD;
                else if (rsp_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant <= sel;
                rsp_id     <= sel;
                rsp_data   <= sh_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (|req_valid && !accept && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: round-robin and fixed-priority copies
// driven by the same stimulus, checked against hand-computed values.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  req_valid;
    logic [31:0] req0_data, req1_data;
    logic [31:0] req0_shamt, req1_shamt;
    logic [1:0]  req0_mode, req1_mode;
    logic        rsp_ready;

    logic [1:0]  rr_ready, fp_ready;
    logic        rr_valid, fp_valid;
    logic        rr_id, fp_id;
    logic [31:0] rr_data, fp_data;
    logic [15:0] rr_stall, fp_stall;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(rr_ready),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
        .req0_mode(req0_mode), .req1_mode(req1_mode),
        .rsp_valid(rr_valid), .rsp_ready(rsp_ready),
        .rsp_id(rr_id), .rsp_data(rr_data), .stall_cnt(rr_stall)
    );

    shift_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(fp_ready),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
        .req0_mode(req0_mode), .req1_mode(req1_mode),
        .rsp_valid(fp_valid), .rsp_ready(rsp_ready),
        .rsp_id(fp_id), .rsp_data(fp_data), .stall_cnt(fp_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One lone request on requester k; result expected the next cycle.
    task automatic single(input int k, input logic [31:0] d,
                          input logic [31:0] s, input logic [1:0] m,
                          input logic [31:0] exp, input string tag);
        if (k == 0) begin
            req0_data = d; req0_shamt = s; req0_mode = m;
        end else begin
            req1_data = d; req1_shamt = s; req1_mode = m;
        end
        req_valid = (k == 0) ? 2'b01 : 2'b10;
        rsp_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, 32'(rr_ready), (k == 0) ? 32'd1 : 32'd2);
        tick();
        req_valid = 2'b00;
        chk({tag, "_vld"}, 32'(rr_valid), 32'd1);
        chk({tag, "_id"}, 32'(rr_id), 32'(k));
        chk({tag, "_data"}, rr_data, exp);
        chk({tag, "_fp_data"}, fp_data, exp);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 2'b11;
        req0_data = '0; req1_data = '0;
        req0_shamt = '0; req1_shamt = '0;
        req0_mode = 2'b00; req1_mode = 2'b00;
        rsp_ready = 1'b1;

        repeat (3) tick();
        chk("rst_vld", 32'(rr_valid), 32'd0);
        chk("rst_id", 32'(rr_id), 32'd0);
        chk("rst_data", rr_data, 32'd0);
        chk("rst_stall", 32'(rr_stall), 32'd0);
        chk("rst_rdy", 32'(rr_ready), 32'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        tick();

        single(0, 32'h8000_0000, 32'd4, 2'b00, 32'h0800_0000, "srl");
        single(1, 32'h8000_0000, 32'd4, 2'b10, 32'hF800_0000, "sra");
        single(0, 32'h0000_1234, 32'd3, 2'b11, 32'h0000_1234, "rsv");
        single(0, 32'h0000_1234, 32'h100, 2'b11, 32'h0, "rsv_big");
        single(0, 32'h8000_0000, 32'd32, 2'b10, 32'h0, "sra32");
        single(0, 32'h0000_0001, 32'd4, 2'b01, 32'h0000_0010, "sll");
        single(1, 32'hFFFF_FFFF, 32'd32, 2'b01, 32'h0, "sll32");

        // Both valid, consumer always ready: RR alternates, FP sticks to 0.
        req0_data = 32'h11; req0_shamt = '0; req0_mode = 2'b00;
        req1_data = 32'h22; req1_shamt = '0; req1_mode = 2'b00;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_rdy", 32'(rr_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("fp_rdy", 32'(fp_ready), 32'd1);
            tick();
            chk("rr_id", 32'(rr_id), 32'(i % 2));
            chk("rr_data", rr_data, (i % 2 == 0) ? 32'h11 : 32'h22);
            chk("rr_vld", 32'(rr_valid), 32'd1);
            chk("fp_id", 32'(fp_id), 32'd0);
        end
        chk("no_stall", 32'(rr_stall), 32'd0);

        // Back-pressure for 5 cycles.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rdy", 32'(rr_ready), 32'd0);
            chk("bp_fp_rdy", 32'(fp_ready), 32'd0);
            chk("bp_data", rr_data, 32'h22);
            tick();
        end
        chk("bp_stall", 32'(rr_stall), 32'd5);
        chk("bp_fp_stall", 32'(fp_stall), 32'd5);
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", 32'(rr_ready), 32'd1);
        tick();
        chk("bp_rel_id", 32'(rr_id), 32'd0);
        chk("bp_rel_data", rr_data, 32'h11);
        chk("bp_rel_stall", 32'(rr_stall), 32'd5);

        // Flush while holding a result.
        rsp_ready = 1'b0;
        flush = 1'b1;
        #1;
        chk("fl_rdy", 32'(rr_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_vld", 32'(rr_valid), 32'd0);
        chk("fl_stall", 32'(rr_stall), 32'd6);
        #1;
        chk("fl_next_rdy", 32'(rr_ready), 32'd2);
        tick();
        chk("fl_next_vld", 32'(rr_valid), 32'd1);
        chk("fl_next_id", 32'(rr_id), 32'd1);
        chk("fl_next_data", rr_data, 32'h22);

        // Reset in the middle of HOLD.
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_vld", 32'(rr_valid), 32'd0);
        chk("mr_stall", 32'(rr_stall), 32'd0);
        chk("mr_rdy", 32'(rr_ready), 32'd0);
        tick();
        chk("mr_hold_vld", 32'(rr_valid), 32'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("mr_first_rdy", 32'(rr_ready), 32'd1);
        tick();
        chk("mr_first_id", 32'(rr_id), 32'd0);
        chk("mr_first_data", rr_data, 32'h11);
        req_valid = 2'b00;
        tick();
        chk("mr_drain_vld", 32'(rr_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous drop of held result; blocks acceptance this cycle.
REQ-005 req_valid  input  2  per-requester request valid (bit 0 = ALU, bit 1 = LSU alignment).
REQ-006 req_ready  output  2  per-requester accept; at most one bit set per cycle.
REQ-007 req0_data, req1_data  input  32 each  operand to shift.
REQ-008 req0_shamt, req1_shamt  input  32 each  shift amount, full width, passed unmodified to the shifter.
REQ-009 req0_mode, req1_mode  input  2 each  shift mode (00 SRL, 01 SLL, 10 SRA, 11 reserved).
REQ-010 rsp_valid  output  1  registered result valid.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  1  index of the requester owning rsp_data.
REQ-013 rsp_data  output  32  registered shift result.
REQ-014 stall_cnt  output  16  saturating count of cycles with any req_valid set and no req_ready set.

Function
REQ-015 One shared shifter instance serves both requesters; the selected requester's data/shamt/mode drive it combinationally.
REQ-016 out_free = ~rsp_valid | rsp_ready; acceptance only when out_free=1 and flush=0.
REQ-017 Grant: single valid requester wins; both valid with RR_EN=1 -> requester other than last_grant wins; RR_EN=0 -> requester 0 wins.
REQ-018 req_ready[k] = out_free & ~flush & grant[k]; req_ready never depends on rsp_ready of a later cycle.
REQ-019 On accept: rsp_data <= shifter result, rsp_id <= k, rsp_valid <= 1, last_grant <= k; latency exactly one cycle.
REQ-020 No accept and rsp_ready=1 -> rsp_valid <= 0; rsp_valid=1 and rsp_ready=0 -> rsp_data/rsp_id held stable.
REQ-021 Accept and rsp_ready in the same cycle -> new result replaces old; full throughput of one result per cycle.
REQ-022 flush=1 -> rsp_valid <= 0, no accept, last_grant unchanged, stall_cnt counts the cycle if any req_valid set.
REQ-023 Requesters hold operands stable while req_valid=1 and req_ready=0; the arbiter does not latch unaccepted requests.
REQ-024 Mode 11 forwarded unchanged; result is whatever the shifter produces (no shift, zero when shamt[31:5]!=0).
REQ-025 shamt >= 32 (any bit [31:5] set) yields 0 for all modes other than 11 semantics above, per shifter.
REQ-026 stall_cnt saturates at 0xFFFF and never wraps.
REQ-027 Arbiter states: EMPTY (rsp_valid=0), HOLD (rsp_valid=1); EMPTY->HOLD on accept, HOLD->EMPTY on rsp_ready without accept or on flush, HOLD->HOLD on accept with rsp_ready.

Reset
REQ-028 rst_n=0 asynchronously forces rsp_valid=0, rsp_id=0, rsp_data=0, stall_cnt=0, last_grant=1 (requester 0 wins first conflict).
REQ-029 req_ready is 0 throughout reset; reset asserted mid-HOLD discards the held result with no response delivered.
REQ-030 Deassertion of rst_n takes effect at the next rising clk edge; first accept no earlier than that edge.

Structure
REQ-031 Shared package shift_pkg holds shift_mode_e (SRL=2'b00, SLL=2'b01, SRA=2'b10, RSV=2'b11) and STALL_CNT_W=16.
REQ-032 The existing shifter_32bit is instantiated once as the sole sub-module; no new shift logic in the arbiter.

Verification
REQ-033 req0 only: data 0x8000_0000, shamt 4, SRL -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0x0800_0000.
REQ-034 req1 only: data 0x8000_0000, shamt 4, SRA -> rsp_id=1, rsp_data=0xF800_0000; SLL shamt 32 on 0xFFFF_FFFF -> 0x0000_0000.
REQ-035 Both valid continuously, rsp_ready=1, RR_EN=1 -> grants 0,1,0,1, one rsp per cycle; RR_EN=0 -> all grants to 0.
REQ-036 rsp_ready=0 for 5 cycles with both valid -> req_ready=00, rsp_data stable, stall_cnt=5; rsp_ready=1 -> accept in that same cycle.
REQ-037 flush while HOLD -> rsp_valid=0 next cycle, no req_ready that cycle; rst_n=0 mid-HOLD -> rsp_valid=0 immediately, stall_cnt=0.
